// File: rtl/csat_pkg.sv
// Shared types and limits for the CSAT assignment sweeper and its tag pipe.
package csat_pkg;

  localparam int SAT_LATENCY_MAX = 3;
  localparam int DRAIN_W         = $clog2(SAT_LATENCY_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SWEEP,
    DRAIN,
    FOUND,
    UNSAT
  } state_e;

endpackage

// File: rtl/csat_tag_pipe.sv
// Fixed-depth delay line aligning issued candidates with the CUT's sat response.
module csat_tag_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, flush};
  end else begin : g_regs
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is cleared, not just the head, because a stale valid
    // bit left in the line would be evaluated as a live candidate later.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/csat_assignment_sweeper.sv
// Exhaustive candidate sweeper for a combinational-SAT circuit under test,
// reporting the first satisfying assignment or exhaustion of the space.
module csat_assignment_sweeper
  import csat_pkg::*;
#(
  parameter int NUM_INPUTS  = 7,
  parameter int SAT_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  resume,
  input  logic                  abort,
  output logic [NUM_INPUTS-1:0] assign_out,
  output logic                  issue_valid,
  input  logic                  sat_in,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  result_sat,
  output logic [NUM_INPUTS-1:0] result_assign,
  output logic [NUM_INPUTS:0]   checks_count
);

  localparam logic [NUM_INPUTS-1:0] ALL_ONES   = '1;
  localparam logic [DRAIN_W-1:0]    DRAIN_INIT =
    DRAIN_W'((SAT_LATENCY > 0) ? SAT_LATENCY - 1 : 0);

  state_e                  state, state_next;
  logic [NUM_INPUTS-1:0]   last_solution;
  logic [DRAIN_W-1:0]      drain_cnt;
  logic [NUM_INPUTS:0]     tag_out;
  logic                    tag_valid;
  logic [NUM_INPUTS-1:0]   tag_assign;
  logic                    hit;

  csat_tag_pipe #(
    .WIDTH (NUM_INPUTS + 1),
    .DEPTH (SAT_LATENCY)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .flush (abort || hit),
    .din   ({issue_valid, assign_out}),
    .dout  (tag_out)
  );

  assign {tag_valid, tag_assign} = tag_out;
  assign hit = (state == SWEEP || state == DRAIN) && tag_valid && sat_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the default keeps state_next fully assigned on every path, so no
  // latch is inferred from the case branches that hold state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (resume && last_solution == ALL_ONES) ? UNSAT : SWEEP;
      SWEEP: begin
        if (hit)                         state_next = FOUND;
        else if (assign_out == ALL_ONES) state_next = (SAT_LATENCY == 0) ? UNSAT : DRAIN;
      end
      DRAIN: begin
        if (hit)                 state_next = FOUND;
        else if (drain_cnt == 0) state_next = UNSAT;
      end
      FOUND, UNSAT: if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_comb begin
    issue_valid  = (state == SWEEP);
    result_valid = (state == FOUND) || (state == UNSAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assign_out    <= '0;
      result_sat    <= 1'b0;
      result_assign <= '0;
      checks_count  <= '0;
      last_solution <= '0;
      drain_cnt     <= '0;
    end else if (!abort) begin
      unique case (state)
        IDLE: if (start) begin
          assign_out    <= resume ? last_solution + 1'b1 : '0;
          result_sat    <= 1'b0;
          result_assign <= '0;
          checks_count  <= '0;
          drain_cnt     <= DRAIN_INIT;
        end
        SWEEP, DRAIN: begin
          if (tag_valid) checks_count <= checks_count + 1'b1;
          if (hit) begin
            result_sat    <= 1'b1;
            result_assign <= tag_assign;
            last_solution <= tag_assign;
          end else if (state == SWEEP) begin
            // Saturate on the last candidate so the space is never swept twice.
            if (assign_out != ALL_ONES) assign_out <= assign_out + 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
